// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: FIFO between fetch and decode on a valid/ready interface.
// Holds up to DEPTH {instr, pc} pairs. A flush drops every wrong-path entry.
// ready_out and valid_out come only from registered occupancy, so there is no
// combinational path from either handshake input to either handshake output.
module fetch_decode_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] pc_in,
    output logic              ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] pc_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  count
);

    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [2*DATA_W-1:0] head;
    logic                enq;
    logic                deq;

    // Handshake flags derived from registered occupancy only
    always_comb begin
        ready_out = (count != CNT_W'(DEPTH));
        valid_out = (count != '0);
        enq       = valid_in && ready_out;
        deq       = valid_out && ready_in;
    end

    // Head entry presentation; all-zero while empty
    always_comb begin
        head      = mem[rd_ptr];
        instr_out = '0;
        pc_out    = '0;
        if (valid_out) begin
            instr_out = head[2*DATA_W-1:DATA_W];
            pc_out    = head[DATA_W-1:0];
        end
    end

    // Storage write; not reset, and a flushed cycle writes nothing
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            mem[wr_ptr] <= {instr_in, pc_in};
        end
    end

    // Pointer and occupancy update; flush overrides any handshake in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed and scoreboard-checked bench for fetch_decode_buffer (DATA_W=32, DEPTH=4).
module tb_fetch_decode_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              valid_in;
    logic [DATA_W-1:0] instr_in;
    logic [DATA_W-1:0] pc_in;
    logic              ready_out;
    logic              valid_out;
    logic [DATA_W-1:0] instr_out;
    logic [DATA_W-1:0] pc_out;
    logic              ready_in;
    logic [CNT_W-1:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_decode_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .valid_in  (valid_in),
        .instr_in  (instr_in),
        .pc_in     (pc_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .instr_out (instr_out),
        .pc_out    (pc_out),
        .ready_in  (ready_in),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] instr_of(input logic [DATA_W-1:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    // Advance one clock; inputs and checks happen 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for one cycle, then drop valid_in
    task automatic push(input logic [DATA_W-1:0] pc);
        valid_in = 1'b1;
        pc_in    = pc;
        instr_in = instr_of(pc);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        pc_in = '0; instr_in = '0;
        tick(); tick();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready_out: got %b want 1", ready_out); end
        n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
        n_cmp++; if (instr_out !== 32'h0) begin n_err++; $display("FAIL reset_instr_out: got %h want 0", instr_out); end
        #3 reset = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) push(32'(4 * i));
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", count); end
        n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL fill_ready_out: got %b want 0", ready_out); end
        push(32'h10);
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_overflow_count: got %0d want 4", count); end
        n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL fill_head_pc: got %h want 0", pc_out); end
    endtask

    task automatic test_drain();
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 1", i, valid_out); end
            n_cmp++; if (pc_out !== 32'(4 * i)) begin n_err++; $display("FAIL drain_pc[%0d]: got %h want %h", i, pc_out, 32'(4 * i)); end
            n_cmp++; if (instr_out !== instr_of(32'(4 * i))) begin n_err++; $display("FAIL drain_instr[%0d]: got %h want %h", i, instr_out, instr_of(32'(4 * i))); end
            tick();
        end
        ready_in = 1'b0;
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL drain_empty_valid: got %b want 0", valid_out); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_empty_count: got %0d want 0", count); end
        n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL drain_empty_ready: got %b want 1", ready_out); end
        n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL drain_empty_pc: got %h want 0", pc_out); end
    endtask

    task automatic test_back_to_back();
        ready_in = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want 1", k, count); end
                n_cmp++; if (pc_out !== 32'(4 * (k - 1))) begin n_err++; $display("FAIL b2b_pc[%0d]: got %h want %h", k, pc_out, 32'(4 * (k - 1))); end
            end
            if (k < 16) begin
                valid_in = 1'b1;
                pc_in    = 32'(4 * k);
                instr_in = instr_of(32'(4 * k));
            end else begin
                valid_in = 1'b0;
            end
            tick();
        end
        ready_in = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_final_count: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        ready_in = 1'b0;
        push(32'h0); push(32'h4); push(32'h8);
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        flush = 1'b1; ready_in = 1'b1;
        valid_in = 1'b1; pc_in = 32'h100; instr_in = instr_of(32'h100);
        tick();
        flush = 1'b0; ready_in = 1'b0; valid_in = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL flush_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL flush_ready_out: got %b want 1", ready_out); end
        push(32'h200);
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL flush_refill_valid: got %b want 1", valid_out); end
        n_cmp++; if (pc_out !== 32'h200) begin n_err++; $display("FAIL flush_refill_pc: got %h want 200", pc_out); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL flush_refill_count: got %0d want 1", count); end
        flush = 1'b1; tick(); flush = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_empty_count: got %0d want 0", count); end
    endtask

    task automatic test_async_reset();
        ready_in = 1'b0;
        push(32'h20); push(32'h24);
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL areset_pre_count: got %0d want 2", count); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL areset_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL areset_count: got %0d want 0", count); end
        n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL areset_ready_out: got %b want 1", ready_out); end
        #1 reset = 1'b0;
        tick();
        push(32'h40);
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL areset_post_valid: got %b want 1", valid_out); end
        n_cmp++; if (pc_out !== 32'h40) begin n_err++; $display("FAIL areset_post_pc: got %h want 40", pc_out); end
        ready_in = 1'b1; tick(); ready_in = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL areset_post_count: got %0d want 0", count); end
    endtask

    task automatic test_hold();
        ready_in = 1'b0;
        push(32'h300); push(32'h304);
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL hold_count: got %0d want 2", count); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", i, valid_out); end
            n_cmp++; if (pc_out !== 32'h300) begin n_err++; $display("FAIL hold_pc[%0d]: got %h want 300", i, pc_out); end
            n_cmp++; if (instr_out !== instr_of(32'h300)) begin n_err++; $display("FAIL hold_instr[%0d]: got %h want %h", i, instr_out, instr_of(32'h300)); end
        end
        flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_random();
        logic [2*DATA_W-1:0] q[$];
        logic                e_enq;
        logic                e_deq;
        for (int c = 0; c < 1000; c++) begin
            valid_in = 1'($urandom_range(0, 1));
            ready_in = 1'($urandom_range(0, 1));
            pc_in    = $urandom;
            instr_in = $urandom;
            n_cmp++; if (count !== CNT_W'(q.size())) begin n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, count, q.size()); end
            n_cmp++; if (count > CNT_W'(DEPTH)) begin n_err++; $display("FAIL rand_count_bound[%0d]: got %0d want <= %0d", c, count, DEPTH); end
            n_cmp++; if (valid_out !== (q.size() != 0)) begin n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", c, valid_out, q.size() != 0); end
            n_cmp++; if (ready_out !== (q.size() != DEPTH)) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, ready_out, q.size() != DEPTH); end
            if (q.size() != 0) begin
                n_cmp++; if ({instr_out, pc_out} !== q[0]) begin n_err++; $display("FAIL rand_head[%0d]: got %h want %h", c, {instr_out, pc_out}, q[0]); end
            end
            e_enq = valid_in && (q.size() != DEPTH);
            e_deq = ready_in && (q.size() != 0);
            if (e_deq) void'(q.pop_front());
            if (e_enq) q.push_back({instr_in, pc_in});
            tick();
        end
        valid_in = 1'b0; ready_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
